ray_setup_unit: RTL and testbench

Per-column ray setup stage for the DDA raycaster. It is the parametrised successor to the single-width ray calculation stage.
- Accepts one screen column (hcount) plus player position, direction and camera plane over a valid/ready handshake.
- Computes cameraX, ray direction, |1/rayDir| delta distances, step signs and initial side distances in signed fixed point.
- Runs one column at a time through a fixed-latency FSM with an internal serial divider, then presents the results to the DDA stepper through a second valid/ready handshake.

---
 rtl/ray_setup_unit.sv | 198 +++++++++++++++++++
 tb/tb_ray_setup_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ray_setup_unit.sv
// ray_setup_unit: per-column DDA ray setup (cameraX, ray direction, delta and side distances).
// Optional map cell outputs map_x_out/map_y_out are enabled by defining RAY_SETUP_MAP_INDEX_EN.
module ray_setup_unit #(
  parameter int WIDTH        = 16,
  parameter int FBITS        = 8,
  parameter int SCREEN_WIDTH = 320,
  parameter int HCOUNT_W     = 9
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  input  logic                valid_in,
  output logic                ready_out,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [WIDTH-1:0]    pos_x_in,
  input  logic [WIDTH-1:0]    pos_y_in,
  input  logic [WIDTH-1:0]    dir_x_in,
  input  logic [WIDTH-1:0]    dir_y_in,
  input  logic [WIDTH-1:0]    plane_x_in,
  input  logic [WIDTH-1:0]    plane_y_in,
  output logic                valid_out,
  input  logic                ready_in,
  output logic [WIDTH-1:0]    ray_dir_x_out,
  output logic [WIDTH-1:0]    ray_dir_y_out,
  output logic                step_x_out,
  output logic                step_y_out,
  output logic [WIDTH-1:0]    delta_dist_x_out,
  output logic [WIDTH-1:0]    delta_dist_y_out,
  output logic [WIDTH-1:0]    side_dist_x_out,
  output logic [WIDTH-1:0]    side_dist_y_out,
  output logic [HCOUNT_W-1:0] hcount_out
`ifdef RAY_SETUP_MAP_INDEX_EN
  ,
  output logic [WIDTH-FBITS-1:0] map_x_out,
  output logic [WIDTH-FBITS-1:0] map_y_out
`endif
);

  // state | meaning
  // IDLE  | waiting for a column request, ready_out=1
  // CAM   | cameraX from hcount
  // RAY   | ray direction, step signs, divisor load
  // DIV   | serial reciprocal, one quotient bit per cycle
  // SIDE  | delta saturation and initial side distances
  // DONE  | results valid until downstream takes them
  typedef enum logic [2:0] {IDLE, CAM, RAY, DIV, SIDE, DONE} state_t;

  localparam int DIV_CYCLES = 2*FBITS + 1;
  localparam int CNT_W      = $clog2(DIV_CYCLES);
  localparam int CAM_K      = (2 << (2*FBITS)) / SCREEN_WIDTH;
  localparam int PW         = 2*WIDTH + 1;
  localparam int PW2        = 2*WIDTH;
  localparam logic [WIDTH-1:0]     ONE_W = WIDTH'(1 << FBITS);
  localparam logic signed [PW-1:0] S_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] S_MIN = ~S_MAX;
  localparam logic [PW-1:0]        U_MAX = {{(PW-WIDTH){1'b0}}, {WIDTH{1'b1}}};

  state_t state, next_state;

  logic [HCOUNT_W-1:0]     hcount_q;
  logic [FBITS-1:0]        frac_x_q, frac_y_q;
  logic [WIDTH-1:0]        dir_x_q, dir_y_q, plane_x_q, plane_y_q;
  logic signed [WIDTH-1:0] cam_x;
  logic [WIDTH-1:0]        dvs_x, dvs_y, rem_x, rem_y;
  logic [DIV_CYCLES-1:0]   quot_x, quot_y;
  logic [CNT_W-1:0]        div_cnt;

  function automatic logic [WIDTH-1:0] sat_s(input logic signed [PW-1:0] v);
    if (v > S_MAX)      return S_MAX[WIDTH-1:0];
    else if (v < S_MIN) return S_MIN[WIDTH-1:0];
    else                return v[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sat_u(input logic [PW-1:0] v);
    return (v > U_MAX) ? {WIDTH{1'b1}} : v[WIDTH-1:0];
  endfunction

  logic [PW-1:0]            cam_prod;
  logic signed [PW2-1:0]    prod_x, prod_y;
  logic signed [PW-1:0]     sum_x, sum_y;
  logic [WIDTH-1:0]         ray_x, ray_y;
  logic                     bit_in;
  logic [WIDTH:0]           rsh_x, rsh_y;
  logic                     ge_x, ge_y;
  logic [WIDTH-1:0]         delta_x, delta_y;
  logic [FBITS:0]           dist_x, dist_y;
  logic [PW-1:0]            sprod_x, sprod_y;

  always_comb begin
    cam_prod = PW'(hcount_q) * PW'(CAM_K);
    prod_x   = PW2'($signed(plane_x_q)) * PW2'(cam_x);
    prod_y   = PW2'($signed(plane_y_q)) * PW2'(cam_x);
    sum_x    = PW'(prod_x >>> FBITS) + PW'($signed(dir_x_q));
    sum_y    = PW'(prod_y >>> FBITS) + PW'($signed(dir_y_q));
    ray_x    = sat_s(sum_x);
    ray_y    = sat_s(sum_y);
    // The dividend is 1<<(2*FBITS): only its first (MSB) bit is set.
    bit_in   = (div_cnt == CNT_W'(DIV_CYCLES-1));
    rsh_x    = {rem_x, bit_in};
    rsh_y    = {rem_y, bit_in};
    ge_x     = (rsh_x >= {1'b0, dvs_x});
    ge_y     = (rsh_y >= {1'b0, dvs_y});
    delta_x  = (dvs_x == '0) ? {WIDTH{1'b1}} : sat_u(PW'(quot_x));
    delta_y  = (dvs_y == '0) ? {WIDTH{1'b1}} : sat_u(PW'(quot_y));
    dist_x   = step_x_out ? ({1'b1, {FBITS{1'b0}}} - {1'b0, frac_x_q}) : {1'b0, frac_x_q};
    dist_y   = step_y_out ? ({1'b1, {FBITS{1'b0}}} - {1'b0, frac_y_q}) : {1'b0, frac_y_q};
    sprod_x  = PW'(dist_x) * PW'(delta_x);
    sprod_y  = PW'(dist_y) * PW'(delta_y);
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready_out  = 1'b0;
    valid_out  = 1'b0;
    case (state)
      IDLE: begin
        ready_out = 1'b1;
        if (valid_in) next_state = CAM;
      end
      CAM:  next_state = RAY;
      RAY:  next_state = DIV;
      DIV:  if (div_cnt == '0) next_state = SIDE;
      SIDE: next_state = DONE;
      DONE: begin
        valid_out = 1'b1;
        if (ready_in) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      hcount_q <= '0; frac_x_q <= '0; frac_y_q <= '0;
      dir_x_q <= '0; dir_y_q <= '0; plane_x_q <= '0; plane_y_q <= '0;
      cam_x <= '0; dvs_x <= '0; dvs_y <= '0; rem_x <= '0; rem_y <= '0;
      quot_x <= '0; quot_y <= '0; div_cnt <= '0;
      ray_dir_x_out <= '0; ray_dir_y_out <= '0; step_x_out <= 1'b0; step_y_out <= 1'b0;
      delta_dist_x_out <= '0; delta_dist_y_out <= '0;
      side_dist_x_out <= '0; side_dist_y_out <= '0; hcount_out <= '0;
`ifdef RAY_SETUP_MAP_INDEX_EN
      map_x_out <= '0; map_y_out <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (valid_in) begin
          hcount_q  <= hcount_in;
          frac_x_q  <= pos_x_in[FBITS-1:0];
          frac_y_q  <= pos_y_in[FBITS-1:0];
          dir_x_q   <= dir_x_in;   dir_y_q   <= dir_y_in;
          plane_x_q <= plane_x_in; plane_y_q <= plane_y_in;
`ifdef RAY_SETUP_MAP_INDEX_EN
          map_x_out <= pos_x_in[WIDTH-1:FBITS];
          map_y_out <= pos_y_in[WIDTH-1:FBITS];
`endif
        end
        CAM: cam_x <= WIDTH'(cam_prod >> FBITS) - ONE_W;
        RAY: begin
          ray_dir_x_out <= ray_x;
          ray_dir_y_out <= ray_y;
          step_x_out    <= ~ray_x[WIDTH-1];
          step_y_out    <= ~ray_y[WIDTH-1];
          dvs_x   <= ray_x[WIDTH-1] ? -ray_x : ray_x;
          dvs_y   <= ray_y[WIDTH-1] ? -ray_y : ray_y;
          rem_x   <= '0; rem_y  <= '0;
          quot_x  <= '0; quot_y <= '0;
          div_cnt <= CNT_W'(DIV_CYCLES-1);
        end
        DIV: begin
          rem_x  <= ge_x ? WIDTH'(rsh_x - {1'b0, dvs_x}) : WIDTH'(rsh_x);
          rem_y  <= ge_y ? WIDTH'(rsh_y - {1'b0, dvs_y}) : WIDTH'(rsh_y);
          quot_x <= {quot_x[DIV_CYCLES-2:0], ge_x};
          quot_y <= {quot_y[DIV_CYCLES-2:0], ge_y};
          if (div_cnt != '0) div_cnt <= div_cnt - CNT_W'(1);
        end
        SIDE: begin
          delta_dist_x_out <= delta_x;
          delta_dist_y_out <= delta_y;
          side_dist_x_out  <= sat_u(sprod_x >> FBITS);
          side_dist_y_out  <= sat_u(sprod_y >> FBITS);
          hcount_out       <= hcount_q;
        end
        default: ;
      endcase
    end
  end

`ifndef RAY_SETUP_MAP_INDEX_EN
  // Map cell bits of the position are consumed by the DDA stage in this build.
  logic unused_pos_int;
  assign unused_pos_int = &{1'b0, pos_x_in[WIDTH-1:FBITS], pos_y_in[WIDTH-1:FBITS]};
`endif

endmodule

// File: tb/tb_ray_setup_unit.sv
// Directed bench for ray_setup_unit: hand-computed column results, latency, backpressure, reset.
module tb_ray_setup_unit;
  logic        pixel_clk_in = 1'b0;
  logic        rst_in = 1'b0, valid_in = 1'b0, ready_in = 1'b0;
  logic [8:0]  hcount_in = '0;
  logic [15:0] pos_x_in = '0, pos_y_in = '0, dir_x_in = '0, dir_y_in = '0;
  logic [15:0] plane_x_in = '0, plane_y_in = '0;
  logic        ready_out, valid_out, step_x_out, step_y_out;
  logic [15:0] ray_dir_x_out, ray_dir_y_out, delta_dist_x_out, delta_dist_y_out;
  logic [15:0] side_dist_x_out, side_dist_y_out;
  logic [8:0]  hcount_out;
`ifdef RAY_SETUP_MAP_INDEX_EN
  logic [7:0]  map_x_out, map_y_out;
`endif

  int vectors = 0, miscompares = 0;

  ray_setup_unit dut (
    .pixel_clk_in(pixel_clk_in), .rst_in(rst_in),
    .valid_in(valid_in), .ready_out(ready_out), .hcount_in(hcount_in),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .dir_x_in(dir_x_in), .dir_y_in(dir_y_in),
    .plane_x_in(plane_x_in), .plane_y_in(plane_y_in),
    .valid_out(valid_out), .ready_in(ready_in),
    .ray_dir_x_out(ray_dir_x_out), .ray_dir_y_out(ray_dir_y_out),
    .step_x_out(step_x_out), .step_y_out(step_y_out),
    .delta_dist_x_out(delta_dist_x_out), .delta_dist_y_out(delta_dist_y_out),
    .side_dist_x_out(side_dist_x_out), .side_dist_y_out(side_dist_y_out),
    .hcount_out(hcount_out)
`ifdef RAY_SETUP_MAP_INDEX_EN
    , .map_x_out(map_x_out), .map_y_out(map_y_out)
`endif
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [8:0] h, input logic [15:0] px, py, dx, dy, plx, ply);
    hcount_in = h; pos_x_in = px; pos_y_in = py;
    dir_x_in = dx; dir_y_in = dy; plane_x_in = plx; plane_y_in = ply;
  endtask

  // Holds valid_in until an edge accepts, then scrambles the inputs.
  task automatic accept_req();
    logic acc;
    int n;
    acc = 1'b0; n = 0;
    valid_in = 1'b1;
    while (!acc && n < 60) begin
      acc = ready_out;
      @(posedge pixel_clk_in); #1;
      n++;
    end
    valid_in = 1'b0;
    set_req(9'h1FF, 16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  // lat counts the accepting edge as 1.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_out && lat < 60) begin
      @(posedge pixel_clk_in); #1;
      lat++;
    end
    if (!valid_out) chk("valid_timeout", 0, 1);
  endtask

  task automatic check_all(input string t, input logic [15:0] rx, ry, input logic sx, sy,
                           input logic [15:0] dx, dy, sdx, sdy, input logic [8:0] hc,
                           input logic [7:0] mx, my);
    chk({t, "_ray_x"}, ray_dir_x_out, rx);
    chk({t, "_ray_y"}, ray_dir_y_out, ry);
    chk({t, "_step_x"}, step_x_out, sx);
    chk({t, "_step_y"}, step_y_out, sy);
    chk({t, "_delta_x"}, delta_dist_x_out, dx);
    chk({t, "_delta_y"}, delta_dist_y_out, dy);
    chk({t, "_side_x"}, side_dist_x_out, sdx);
    chk({t, "_side_y"}, side_dist_y_out, sdy);
    chk({t, "_hcount"}, hcount_out, hc);
`ifdef RAY_SETUP_MAP_INDEX_EN
    chk({t, "_map_x"}, map_x_out, mx);
    chk({t, "_map_y"}, map_y_out, my);
`else
    if (mx != my) vectors = vectors + 0;
`endif
  endtask

  task automatic finish_xfer();
    ready_in = 1'b1;
    @(posedge pixel_clk_in); #1;
  endtask

  initial begin
    int lat, cyc, k_in, k_out;
    int t_out[3];
    logic [8:0] h_out[3];
    logic acc;

    // Reset
    rst_in = 1'b0;
    repeat (2) @(posedge pixel_clk_in);
    #1;
    chk("rst_ready", ready_out, 1);
    chk("rst_valid", valid_out, 0);
    check_all("rst", 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 9'd0, 8'd0, 8'd0);
    rst_in = 1'b1;
    ready_in = 1'b1;
    @(posedge pixel_clk_in); #1;

    // Basic column
    set_req(9'd0, 16'h0380, 16'h0240, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
    accept_req();
    wait_valid(lat);
    chk("basic_latency", lat, 21);
    chk("basic_ready_busy", ready_out, 0);
    check_all("basic", 16'h0100, 16'hFF57, 1'b1, 1'b0, 16'd256, 16'd387, 16'd128, 16'd96,
              9'd0, 8'd3, 8'd2);
    finish_xfer();

    // Zero ray component
    set_req(9'd0, 16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0000);
    accept_req();
    wait_valid(lat);
    chk("zero_latency", lat, 21);
    check_all("zero", 16'h0000, 16'h0100, 1'b1, 1'b1, 16'hFFFF, 16'd256, 16'hFFFF, 16'd256,
              9'd0, 8'd1, 8'd1);
    finish_xfer();

    // Centre column: cameraX = -1
    set_req(9'd160, 16'h0380, 16'h0240, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
    accept_req();
    wait_valid(lat);
    chk("centre_latency", lat, 21);
    check_all("centre", 16'h0100, 16'hFFFF, 1'b1, 1'b0, 16'd256, 16'hFFFF, 16'd128, 16'h3FFF,
              9'd160, 8'd3, 8'd2);
    finish_xfer();

    // Backpressure with a competing request
    ready_in = 1'b0;
    set_req(9'd0, 16'h0380, 16'h0240, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
    accept_req();
    wait_valid(lat);
    chk("bp_latency", lat, 21);
    set_req(9'd160, 16'h0380, 16'h0240, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
    valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge pixel_clk_in); #1;
      chk("bp_hold_valid", valid_out, 1);
      chk("bp_hold_ready", ready_out, 0);
      chk("bp_hold_hcount", hcount_out, 0);
      chk("bp_hold_ray_y", ray_dir_y_out, 16'hFF57);
      chk("bp_hold_side_y", side_dist_y_out, 16'd96);
    end
    ready_in = 1'b1;
    @(posedge pixel_clk_in); #1;
    chk("bp_after_xfer_ready", ready_out, 1);
    chk("bp_after_xfer_valid", valid_out, 0);
    @(posedge pixel_clk_in); #1;
    valid_in = 1'b0;
    chk("bp_second_accepted", ready_out, 0);
    wait_valid(lat);
    chk("bp_second_latency", lat, 21);
    check_all("bp2", 16'h0100, 16'hFFFF, 1'b1, 1'b0, 16'd256, 16'hFFFF, 16'd128, 16'h3FFF,
              9'd160, 8'd3, 8'd2);
    finish_xfer();

    // Back-to-back, valid_in held high
    set_req(9'd10, 16'h0380, 16'h0240, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
    ready_in = 1'b1; valid_in = 1'b1;
    k_in = 0; k_out = 0; cyc = 0;
    while (k_out < 3 && cyc < 200) begin
      acc = ready_out && valid_in;
      @(posedge pixel_clk_in); #1;
      cyc++;
      if (acc) begin
        k_in++;
        hcount_in = 9'(10 * (k_in + 1));
        if (k_in == 3) valid_in = 1'b0;
      end
      if (valid_out) begin
        t_out[k_out] = cyc;
        h_out[k_out] = hcount_out;
        k_out++;
      end
    end
    valid_in = 1'b0;
    chk("b2b_count", k_out, 3);
    if (k_out == 3) begin
      chk("b2b_first_lat", t_out[0], 21);
      chk("b2b_gap1", t_out[1] - t_out[0], 22);
      chk("b2b_gap2", t_out[2] - t_out[1], 22);
      chk("b2b_h0", h_out[0], 10);
      chk("b2b_h1", h_out[1], 20);
      chk("b2b_h2", h_out[2], 30);
    end
    @(posedge pixel_clk_in); #1;

    // Reset during DIV
    set_req(9'd0, 16'h0380, 16'h0240, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
    accept_req();
    repeat (7) @(posedge pixel_clk_in);
    #1;
    rst_in = 1'b0;
    @(posedge pixel_clk_in); #1;
    rst_in = 1'b1;
    chk("mrst_valid", valid_out, 0);
    chk("mrst_ready", ready_out, 1);
    check_all("mrst", 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 9'd0, 8'd0, 8'd0);
    set_req(9'd160, 16'h0380, 16'h0240, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
    accept_req();
    wait_valid(lat);
    chk("post_rst_latency", lat, 21);
    check_all("post_rst", 16'h0100, 16'hFFFF, 1'b1, 1'b0, 16'd256, 16'hFFFF, 16'd128, 16'h3FFF,
              9'd160, 8'd3, 8'd2);
    finish_xfer();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
